// File: rtl/my_ram_pkg.sv
// Shared types and default widths for the my_ram clear-on-reset memory.
package my_ram_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage : my_ram_pkg

// File: rtl/my_ram_ram_core.sv
// Simple dual-port storage: one write port, one registered read port with
// write-first bypass and a synchronous read-data clear.
module ram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              rd_clr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read-data next value: forced to zero while clearing, write-first on collision.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr_i) begin
      rdata_d = {DATA_W{1'b0}};
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
    end else begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Storage array is deliberately not reset; contents are zeroed by the clear sweep.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : ram_core

// File: rtl/my_ram.sv
// Dual-port RAM that sweeps every word to zero after reset before accepting
// user writes; init_done flags the end of the sweep.
module my_ram
  import my_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clka,
  input  logic              rst,
  input  logic [0:0]        wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;

  logic              core_we_s;
  logic [ADDR_W-1:0] core_waddr_s;
  logic [DATA_W-1:0] core_wdata_s;
  logic              core_rd_clr_s;

  // Clear FSM and write-port mux: the sweep owns port A until it finishes.
  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    init_done_d   = init_done_q;
    core_we_s     = 1'b1;
    core_waddr_s  = clr_ptr_q;
    core_wdata_s  = {DATA_W{1'b0}};
    core_rd_clr_s = 1'b1;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
          clr_ptr_d   = {ADDR_W{1'b0}};
        end else begin
          clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        core_we_s     = wea[0];
        core_waddr_s  = addra;
        core_wdata_s  = dina;
        core_rd_clr_s = 1'b0;
      end
      default: begin
        state_d     = ST_CLEAR;
        clr_ptr_d   = {ADDR_W{1'b0}};
        init_done_d = 1'b0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= {ADDR_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram_core (
    .clk_i    (clka),
    .rst_i    (rst),
    .we_i     (core_we_s),
    .waddr_i  (core_waddr_s),
    .wdata_i  (core_wdata_s),
    .raddr_i  (addrb),
    .rd_clr_i (core_rd_clr_s),
    .rdata_o  (doutb)
  );

  assign init_done = init_done_q;

endmodule : my_ram

// File: tb/tb_my_ram.sv
// Directed self-checking bench for my_ram: clear sweep timing, reads, writes,
// write-first collision and reset abort.
module tb_my_ram;

  logic        clka = 1'b0;
  logic        rst;
  logic [0:0]  wea;
  logic [5:0]  addra;
  logic [31:0] dina;
  logic [5:0]  addrb;
  logic [31:0] doutb;
  logic        init_done;

  int checks   = 0;
  int failures = 0;

  my_ram dut (
    .clka      (clka),
    .rst       (rst),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .addrb     (addrb),
    .doutb     (doutb),
    .init_done (init_done)
  );

  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Run a full sweep from reset release: init_done low after 63 edges, high after 64.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 63; i++) begin
      tick();
      if (i == 10) check_eq({tag, "_dout_clear"}, doutb, 32'h0000_0000);
    end
    check_eq({tag, "_done_63"}, {31'd0, init_done}, 32'd0);
    tick();
    check_eq({tag, "_done_64"}, {31'd0, init_done}, 32'd1);
  endtask

  task automatic read_all_zero(input string tag);
    wea = 1'b0;
    for (int a = 0; a < 64; a++) begin
      addrb = 6'(a);
      tick();
      check_eq(tag, doutb, 32'h0000_0000);
    end
  endtask

  initial begin
    rst   = 1'b1;
    wea   = 1'b0;
    addra = 6'd0;
    dina  = 32'h0000_0000;
    addrb = 6'd0;
    #50;
    check_eq("rst_dout", doutb, 32'h0000_0000);
    check_eq("rst_done", {31'd0, init_done}, 32'd0);
    #50;
    rst = 1'b0;
    // Port A traffic during the sweep must be ignored.
    wea   = 1'b1;
    addra = 6'd7;
    dina  = 32'hFFFF_FFFF;
    addrb = 6'd7;
    check_sweep("init");
    read_all_zero("zero_init");

    // Plain write then reads.
    wea = 1'b1; addra = 6'd5; dina = 32'hDEAD_BEEF; addrb = 6'd0;
    tick();
    wea = 1'b0; addrb = 6'd5;
    tick();
    check_eq("rd5", doutb, 32'hDEAD_BEEF);
    addrb = 6'd6;
    tick();
    check_eq("rd6", doutb, 32'h0000_0000);

    // wea=0 must leave memory untouched.
    wea = 1'b0; addra = 6'd5; dina = 32'h1111_2222; addrb = 6'd6;
    tick();
    addrb = 6'd5;
    tick();
    check_eq("nowrite5", doutb, 32'hDEAD_BEEF);

    // Write-first collision.
    wea = 1'b1; addra = 6'd10; dina = 32'h1234_5678; addrb = 6'd10;
    tick();
    check_eq("wfirst10", doutb, 32'h1234_5678);
    wea = 1'b0;
    tick();
    check_eq("rd10", doutb, 32'h1234_5678);

    // Independent write/read on different addresses.
    wea = 1'b1; addra = 6'd3; dina = 32'hA5A5_A5A5; addrb = 6'd0;
    tick();
    wea = 1'b1; addra = 6'd3; dina = 32'h5A5A_5A5A; addrb = 6'd4;
    tick();
    check_eq("indep_rd4", doutb, 32'h0000_0000);
    wea = 1'b0; addrb = 6'd3;
    tick();
    check_eq("rd3", doutb, 32'h5A5A_5A5A);
    wea = 1'b1; addra = 6'd63; dina = 32'h0BAD_F00D; addrb = 6'd3;
    tick();
    check_eq("indep_rd3", doutb, 32'h5A5A_5A5A);
    wea = 1'b0; addrb = 6'd63;
    tick();
    check_eq("rd63", doutb, 32'h0BAD_F00D);

    // Reset in READY: doutb clears immediately.
    addrb = 6'd5;
    tick();
    check_eq("pre_rst_rd5", doutb, 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ready_rst_dout", doutb, 32'h0000_0000);
    check_eq("ready_rst_done", {31'd0, init_done}, 32'd0);
    tick();
    rst = 1'b0;

    // Abort the sweep after 20 cycles.
    for (int i = 0; i < 20; i++) tick();
    check_eq("mid_done", {31'd0, init_done}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_dout", doutb, 32'h0000_0000);
    check_eq("mid_rst_done", {31'd0, init_done}, 32'd0);
    tick();
    rst = 1'b0;
    check_sweep("rerun");
    read_all_zero("zero_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_my_ram
